// File: rtl/pe_host_sequencer.sv
// Standalone run controller for one PE: reset, config load over MMIO, execute, drain, result read.
// Optional RUN/DRAIN watchdog is compiled in when PE_SEQ_TIMEOUT_EN is defined.
module pe_host_sequencer #(
   parameter int INDEX_WIDTH     = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int COUNT_WIDTH     = 32,
   parameter int PE_RESET_CYCLES = 4,
   parameter int RESULT_INDEX    = 0,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [DATA_WIDTH-1:0]  result,
   output logic [COUNT_WIDTH-1:0] cycle_count,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [INDEX_WIDTH-1:0] cfg_index,
   input  logic [DATA_WIDTH-1:0]  cfg_data,
   input  logic                   cfg_last,
   output logic                   pe_reset,
   output logic                   pe_enable,
   output logic                   pe_execute,
   input  logic                   pe_halted,
   input  logic                   pe_channels_quiescent,
   input  logic                   pe_router_quiescent,
   output logic                   host_write_req,
   input  logic                   host_write_ack,
   output logic [INDEX_WIDTH-1:0] host_write_index,
   output logic [DATA_WIDTH-1:0]  host_write_data,
   output logic                   host_read_req,
   input  logic                   host_read_ack,
   output logic [INDEX_WIDTH-1:0] host_read_index,
   input  logic [DATA_WIDTH-1:0]  host_read_data
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PE_RESET = 3'd1,
      S_LOAD     = 3'd2,
      S_RUN      = 3'd3,
      S_DRAIN    = 3'd4,
      S_READ     = 3'd5,
      S_DONE     = 3'd6,
      S_ERROR    = 3'd7
   } state_e;

   localparam int RST_W = (PE_RESET_CYCLES > 1) ? $clog2(PE_RESET_CYCLES) : 1;
   localparam logic [RST_W-1:0]       RST_LAST = RST_W'(PE_RESET_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

   state_e                 state_q, state_d;
   logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
   logic                   wr_pend_q, wr_pend_d;
   logic                   wr_last_q, wr_last_d;
   logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   cfg_ready_q, cfg_ready_d;
   logic                   pe_reset_q, pe_reset_d;
   logic                   pe_enable_q, pe_enable_d;
   logic                   pe_execute_q, pe_execute_d;
   logic                   rd_req_q, rd_req_d;
   logic [INDEX_WIDTH-1:0] rd_index_q, rd_index_d;
   logic                   wd_expire_s;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      wr_pend_d  = wr_pend_q;
      wr_last_d  = wr_last_q;
      wr_index_d = wr_index_q;
      wr_data_d  = wr_data_q;
      result_d   = result_q;
      count_d    = count_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d   = S_PE_RESET;
               rst_cnt_d = {RST_W{1'b0}};
               count_d   = {COUNT_WIDTH{1'b0}};
               result_d  = {DATA_WIDTH{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         S_PE_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = S_LOAD;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1'b1);
            end
         end
         S_LOAD: begin
            // One write in flight at a time; the next word is taken only after its ack.
            if (wr_pend_q) begin
               if (host_write_ack) begin
                  wr_pend_d = 1'b0;
                  state_d   = wr_last_q ? S_RUN : S_LOAD;
               end else begin
                  wr_pend_d = 1'b1;
               end
            end else if (cfg_valid) begin
               wr_pend_d  = 1'b1;
               wr_last_d  = cfg_last;
               wr_index_d = cfg_index;
               wr_data_d  = cfg_data;
            end else begin
               wr_pend_d = 1'b0;
            end
         end
         S_RUN: begin
            if (count_q != CNT_MAX) begin
               count_d = count_q + COUNT_WIDTH'(1'b1);
            end else begin
               count_d = count_q;
            end
            if (wd_expire_s) begin
               state_d = S_ERROR;
            end else if (pe_halted) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (wd_expire_s) begin
               state_d = S_ERROR;
            end else if (pe_channels_quiescent && pe_router_quiescent) begin
               state_d = S_READ;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_READ: begin
            if (host_read_ack) begin
               result_d = host_read_data;
               state_d  = S_DONE;
            end else begin
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d       = state_d inside {S_PE_RESET, S_LOAD, S_RUN, S_DRAIN, S_READ};
      done_d       = (state_d == S_DONE);
      pe_reset_d   = (state_d == S_IDLE) || (state_d == S_PE_RESET);
      pe_enable_d  = state_d inside {S_LOAD, S_RUN, S_DRAIN, S_READ};
      pe_execute_d = (state_d == S_RUN);
      cfg_ready_d  = (state_d == S_LOAD) && !wr_pend_d;
      rd_req_d     = (state_d == S_READ);
      rd_index_d   = rd_req_d ? INDEX_WIDTH'(RESULT_INDEX) : {INDEX_WIDTH{1'b0}};
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rst_cnt_q    <= {RST_W{1'b0}};
         wr_pend_q    <= 1'b0;
         wr_last_q    <= 1'b0;
         wr_index_q   <= {INDEX_WIDTH{1'b0}};
         wr_data_q    <= {DATA_WIDTH{1'b0}};
         result_q     <= {DATA_WIDTH{1'b0}};
         count_q      <= {COUNT_WIDTH{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_ready_q  <= 1'b0;
         pe_reset_q   <= 1'b1;
         pe_enable_q  <= 1'b0;
         pe_execute_q <= 1'b0;
         rd_req_q     <= 1'b0;
         rd_index_q   <= {INDEX_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         wr_pend_q    <= wr_pend_d;
         wr_last_q    <= wr_last_d;
         wr_index_q   <= wr_index_d;
         wr_data_q    <= wr_data_d;
         result_q     <= result_d;
         count_q      <= count_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_ready_q  <= cfg_ready_d;
         pe_reset_q   <= pe_reset_d;
         pe_enable_q  <= pe_enable_d;
         pe_execute_q <= pe_execute_d;
         rd_req_q     <= rd_req_d;
         rd_index_q   <= rd_index_d;
      end
   end

`ifdef PE_SEQ_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wd_q;
   logic            error_q;

   assign wd_expire_s = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog over RUN+DRAIN and the registered error flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_q    <= {WD_W{1'b0}};
         error_q <= 1'b0;
      end else begin
         if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
            wd_q <= wd_q + WD_W'(1'b1);
         end else begin
            wd_q <= {WD_W{1'b0}};
         end
         error_q <= (state_d == S_ERROR);
      end
   end

   assign error = error_q;
`else
   assign wd_expire_s = 1'b0;
   assign error       = 1'b0;
`endif

   assign busy             = busy_q;
   assign done             = done_q;
   assign result           = result_q;
   assign cycle_count      = count_q;
   assign cfg_ready        = cfg_ready_q;
   assign pe_reset         = pe_reset_q;
   assign pe_enable        = pe_enable_q;
   assign pe_execute       = pe_execute_q;
   assign host_write_req   = wr_pend_q;
   assign host_write_index = wr_index_q;
   assign host_write_data  = wr_data_q;
   assign host_read_req    = rd_req_q;
   assign host_read_index  = rd_index_q;

endmodule

// File: tb/tb_pe_host_sequencer.sv
// Directed bench for pe_host_sequencer: table of runs plus hand-written reset and watchdog sequences.
`timescale 1ns/1ps
module tb_pe_host_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, start, busy, done, error;
   logic [31:0] result, cycle_count;
   logic        cfg_valid, cfg_ready, cfg_last;
   logic [15:0] cfg_index;
   logic [31:0] cfg_data;
   logic        pe_reset, pe_enable, pe_execute;
   logic        pe_halted, pe_channels_quiescent, pe_router_quiescent;
   logic        host_write_req, host_write_ack;
   logic [15:0] host_write_index;
   logic [31:0] host_write_data;
   logic        host_read_req, host_read_ack;
   logic [15:0] host_read_index;
   logic [31:0] host_read_data;

   always #5 clk = ~clk;

   pe_host_sequencer #(
      .INDEX_WIDTH(16), .DATA_WIDTH(32), .COUNT_WIDTH(32),
      .PE_RESET_CYCLES(4), .RESULT_INDEX(0), .TIMEOUT_CYCLES(100)
   ) dut (
      .clock(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
      .result(result), .cycle_count(cycle_count),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index), .cfg_data(cfg_data),
      .cfg_last(cfg_last),
      .pe_reset(pe_reset), .pe_enable(pe_enable), .pe_execute(pe_execute), .pe_halted(pe_halted),
      .pe_channels_quiescent(pe_channels_quiescent), .pe_router_quiescent(pe_router_quiescent),
      .host_write_req(host_write_req), .host_write_ack(host_write_ack),
      .host_write_index(host_write_index), .host_write_data(host_write_data),
      .host_read_req(host_read_req), .host_read_ack(host_read_ack),
      .host_read_index(host_read_index), .host_read_data(host_read_data)
   );

   typedef struct {
      int          nwords;
      int          ack_dly;
      int          run_cyc;
      int          router_dly;
      logic [31:0] rdata;
      logic        busy_starts;
      logic [31:0] exp_count;
      logic [31:0] exp_result;
   } run_t;

   run_t        tbl[5];
   int          n_vec = 0;
   int          n_fail = 0;
   int          ack_dly = 0;
   int          rd_dly = 1;
   logic [15:0] wq_idx[$];
   logic [31:0] wq_dat[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // MMIO write slave: acks after ack_dly waiting cycles, checks stability and back-pressure.
   initial begin : wr_resp
      int          wcnt;
      logic [15:0] hi;
      logic [31:0] hd;
      wcnt = 0; hi = '0; hd = '0;
      host_write_ack = 1'b0;
      forever begin
         @(negedge clk);
         host_write_ack = 1'b0;
         if (host_write_req) begin
            if (wcnt == 0) begin
               hi = host_write_index;
               hd = host_write_data;
            end else begin
               chk("wr_index_stable", host_write_index, hi);
               chk("wr_data_stable", host_write_data, hd);
            end
            chk("cfg_ready_while_wr", cfg_ready, 0);
            if (wcnt >= ack_dly) begin
               host_write_ack = 1'b1;
               wq_idx.push_back(hi);
               wq_dat.push_back(hd);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // MMIO read slave: acks after rd_dly waiting cycles.
   initial begin : rd_resp
      int rcnt;
      rcnt = 0;
      host_read_ack = 1'b0;
      forever begin
         @(negedge clk);
         host_read_ack = 1'b0;
         if (host_read_req) begin
            chk("rd_index", host_read_index, 0);
            if (rcnt >= rd_dly) begin
               host_read_ack = 1'b1;
               rcnt = 0;
            end else begin
               rcnt++;
            end
         end else begin
            rcnt = 0;
         end
      end
   end

   task automatic check_idle_outputs();
      chk("rst_pe_reset", pe_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_result", result, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_pe_enable", pe_enable, 0);
      chk("rst_pe_execute", pe_execute, 0);
      chk("rst_wr_req", host_write_req, 0);
      chk("rst_rd_req", host_read_req, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_enable(output int nrst);
      nrst = 0;
      for (int k = 0; k < 20 && !pe_enable; k++) begin
         if (pe_reset) nrst++;
         @(negedge clk);
      end
      if (!pe_enable) timeout("wait_pe_enable");
   endtask

   task automatic feed_words(input int r, input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         cfg_valid = 1'b1;
         cfg_index = 16'(16'h0010 + i);
         cfg_data  = 32'hC0DE_0000 | 32'(r << 8) | 32'(i);
         cfg_last  = (i == n - 1);
         ok = 1'b0;
         for (int k = 0; k < 100 && !ok; k++) begin
            ok = cfg_ready;
            @(negedge clk);
         end
         if (!ok) timeout("cfg_accept");
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic wait_execute();
      for (int k = 0; k < 200 && !pe_execute; k++) @(negedge clk);
      if (!pe_execute) timeout("wait_execute");
   endtask

   task automatic do_run(input int r, input run_t t);
      int nrst;
      wq_idx.delete();
      wq_dat.delete();
      ack_dly = t.ack_dly;
      host_read_data = t.rdata;
      pe_halted = 1'b0;
      pe_channels_quiescent = 1'b1;
      pe_router_quiescent = (t.router_dly == 0);
      pulse_start();
      chk("busy_after_start", busy, 1);
      chk("count_cleared", cycle_count, 0);
      chk("result_cleared", result, 0);
      chk("done_cleared", done, 0);
      chk("error_cleared", error, 0);
      chk("enable_in_pe_reset", pe_enable, 0);
      wait_enable(nrst);
      chk("pe_reset_cycles", nrst, 4);
      chk("pe_reset_low_in_load", pe_reset, 0);
      if (t.busy_starts) pulse_start();
      feed_words(r, t.nwords);
      wait_execute();
      chk("wr_count", wq_idx.size(), t.nwords);
      for (int i = 0; i < t.nwords && i < wq_idx.size(); i++) begin
         chk("wr_index", wq_idx[i], 16'(16'h0010 + i));
         chk("wr_data", wq_dat[i], 32'hC0DE_0000 | 32'(r << 8) | 32'(i));
      end
      for (int k = 1; k <= t.run_cyc; k++) begin
         if (k == t.run_cyc) pe_halted = 1'b1;
         start = t.busy_starts && (k == 5);
         @(negedge clk);
      end
      start = 1'b0;
      chk("exec_in_drain", pe_execute, 0);
      chk("enable_in_drain", pe_enable, 1);
      for (int d = 0; d < t.router_dly; d++) begin
         chk("rd_req_before_quiescent", host_read_req, 0);
         chk("exec_drain_hold", pe_execute, 0);
         if (d == t.router_dly - 1) pe_router_quiescent = 1'b1;
         @(negedge clk);
      end
      for (int k = 0; k < 50 && !done; k++) @(negedge clk);
      if (!done) timeout("wait_done");
      chk("done", done, 1);
      chk("busy_in_done", busy, 0);
      chk("result", result, t.exp_result);
      chk("cycle_count", cycle_count, t.exp_count);
      chk("enable_in_done", pe_enable, 0);
      chk("exec_in_done", pe_execute, 0);
      chk("pe_reset_in_done", pe_reset, 0);
      chk("rd_req_in_done", host_read_req, 0);
      repeat (3) @(negedge clk);
      chk("done_hold", done, 1);
      chk("busy_hold", busy, 0);
      chk("count_hold", cycle_count, t.exp_count);
      pe_halted = 1'b0;
      pe_router_quiescent = 1'b0;
   endtask

   initial begin : main
      int nrst;
      reset_n = 1'b0; start = 1'b0;
      cfg_valid = 1'b0; cfg_index = '0; cfg_data = '0; cfg_last = 1'b0;
      pe_halted = 1'b0; pe_channels_quiescent = 1'b0; pe_router_quiescent = 1'b0;
      host_read_data = '0;

      tbl[0] = '{3, 1, 50, 0,  32'hDEAD_BEEF, 1'b0, 32'd50, 32'hDEAD_BEEF};
      tbl[1] = '{3, 5, 7,  0,  32'h1234_5678, 1'b0, 32'd7,  32'h1234_5678};
      tbl[2] = '{2, 0, 3,  10, 32'hA5A5_5A5A, 1'b0, 32'd3,  32'hA5A5_5A5A};
      tbl[3] = '{1, 2, 12, 2,  32'h0F0F_0F0F, 1'b1, 32'd12, 32'h0F0F_0F0F};
      tbl[4] = '{4, 0, 1,  1,  32'hFFFF_FFFF, 1'b0, 32'd1,  32'hFFFF_FFFF};

      repeat (3) @(negedge clk);
      check_idle_outputs();
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_pe_reset", pe_reset, 1);
      chk("idle_busy", busy, 0);

      for (int r = 0; r < 5; r++) do_run(r, tbl[r]);

      // Reset asserted asynchronously at RUN cycle 20, then a clean run.
      ack_dly = 0;
      pe_halted = 1'b0;
      pulse_start();
      wait_enable(nrst);
      feed_words(9, 1);
      wait_execute();
      repeat (19) @(negedge clk);
      chk("mid_run_exec", pe_execute, 1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs();
      do_run(5, tbl[0]);

`ifdef PE_SEQ_TIMEOUT_EN
      begin : watchdog
         int n;
         pe_halted = 1'b0;
         pulse_start();
         wait_enable(nrst);
         feed_words(7, 1);
         wait_execute();
         n = 0;
         for (int k = 0; k < 300 && pe_execute; k++) begin
            n++;
            @(negedge clk);
         end
         chk("wd_run_cycles", n, 100);
         chk("wd_error", error, 1);
         chk("wd_done", done, 0);
         chk("wd_exec", pe_execute, 0);
         chk("wd_enable", pe_enable, 0);
         chk("wd_busy", busy, 0);
         chk("wd_result", result, 0);
         do_run(6, tbl[4]);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_host_sequencer.md
Name: pe_host_sequencer

Overview:
Autonomous run controller for one processing element.
- Resets the PE, streams configuration words into it over its MMIO host write port, asserts execute, and waits for halt and network quiescence.
- Reads back one result word over the MMIO read port and reports done.
- Sits between a config source (DMA/ROM streamer) and the PE's host, control and status pins, replacing a software host for standalone runs.

Parameters:
INDEX_WIDTH, 16, MMIO index width (matches TIA_MMIO_INDEX_WIDTH).
DATA_WIDTH, 32, MMIO data width (matches TIA_MMIO_DATA_WIDTH).
COUNT_WIDTH, 32, width of the run cycle counter.
PE_RESET_CYCLES, 4, cycles pe_reset is held high at run start (>=1).
RESULT_INDEX, 0, MMIO index read back after the run.
TIMEOUT_CYCLES, 1000000, watchdog limit (used only with the optional feature).

Ports:
clock  in  1  positive-edge clock.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  start pulse; sampled only in IDLE, DONE or ERROR.
busy  out  1  high from the cycle after start until DONE/ERROR.
done  out  1  high in DONE.
error  out  1  high in ERROR.
result  out  DATA_WIDTH  word read from RESULT_INDEX.
cycle_count  out  COUNT_WIDTH  cycles spent in RUN.
cfg_valid  in  1  config word valid.
cfg_ready  out  1  sequencer accepts a config word.
cfg_index  in  INDEX_WIDTH  MMIO index of the config word.
cfg_data  in  DATA_WIDTH  config word.
cfg_last  in  1  final config word.
pe_reset  out  1  PE reset, active high.
pe_enable  out  1  PE enable.
pe_execute  out  1  PE execute.
pe_halted  in  1  PE halted.
pe_channels_quiescent  in  1  PE channel buffers empty.
pe_router_quiescent  in  1  PE router buffers empty.
host_write_req  out  1  MMIO write request.
host_write_ack  in  1  MMIO write acknowledge.
host_write_index  out  INDEX_WIDTH  MMIO write index.
host_write_data  out  DATA_WIDTH  MMIO write data.
host_read_req  out  1  MMIO read request.
host_read_ack  in  1  MMIO read acknowledge.
host_read_index  out  INDEX_WIDTH  MMIO read index.
host_read_data  in  DATA_WIDTH  MMIO read data.

Behaviour:
- Reset (async, reset_n low): state IDLE.
  - pe_reset=1.
  - All other outputs 0, including result and cycle_count.
  - Any in-flight MMIO request is dropped.
- MMIO handshake:
  - A request is held high with stable index/data until a cycle in which ack=1.
  - The transfer completes on that edge and req deasserts the following cycle.
  - At most one outstanding request.
- IDLE:
  - pe_reset=1, busy=0.
  - start=1 -> PE_RESET next cycle; busy=1; cycle_count, result, done and error cleared.
- PE_RESET:
  - pe_reset=1 for exactly PE_RESET_CYCLES cycles, then -> LOAD.
  - pe_reset=0 and pe_enable=1 from LOAD onward until DONE/ERROR.
- LOAD:
  - cfg_ready=1 only when no write is outstanding.
  - On cfg_valid&cfg_ready, latch index/data/last; host_write_req rises the next cycle.
  - cfg_ready=0 until the ack completes.
  - After the ack of a word latched with last=1 -> RUN; otherwise accept the next word.
  - cfg_valid low simply stalls.
- RUN:
  - pe_execute=1.
  - cycle_count increments each cycle in RUN and saturates at all-ones (no wrap).
  - pe_halted=1 -> DRAIN; execute drops in the same transition.
- DRAIN: -> READ on the first cycle with pe_channels_quiescent=1 and pe_router_quiescent=1.
- READ:
  - host_read_req=1, host_read_index=RESULT_INDEX.
  - On ack, result<=host_read_data -> DONE.
- DONE:
  - done=1, busy=0, pe_enable=0, pe_execute=0.
  - pe_reset=0; the PE state is retained for host inspection.
  - result and cycle_count are held.
  - start -> PE_RESET (done clears).
- start while busy is ignored.
- reset_n asserted mid-operation forces IDLE immediately; the PE is re-held in reset.

Optional Feature:
PE_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles spent in RUN+DRAIN.
  - Reaching TIMEOUT_CYCLES -> ERROR: error=1, busy=0, pe_execute=0, pe_enable=0.
  - result is not updated.
  - start leaves ERROR to PE_RESET and clears error.
- Undefined:
  - No watchdog logic; error is tied 0.
  - RUN/DRAIN wait indefinitely.

Test Plan:
- Nominal run:
  - Stimulus: start; 3 cfg words (idx 0x10/0x11/0x12, last on the third), ack after 1 cycle; pe_halted after 50 RUN cycles; quiescent immediately; read_data=0xDEADBEEF.
  - Required response: three writes with matching index/data in order; cycle_count=50; result=0xDEADBEEF; done=1; busy=0.
- Back-pressure:
  - Stimulus: host_write_ack delayed 5 cycles per word; cfg_valid held high.
  - Required response: cfg_ready=0 while a write is outstanding; req/index/data stable throughout; no word lost or duplicated.
- Drain ordering:
  - Stimulus: halted=1, channels_quiescent=1, router_quiescent=0 for 10 cycles, then 1.
  - Required response: host_read_req rises only after both quiescent inputs are high; pe_execute=0 during DRAIN.
- Mid-run reset:
  - Stimulus: reset_n low in RUN at cycle 20.
  - Required response: all outputs return to reset values asynchronously with pe_reset=1; a subsequent start runs cleanly.
- Start while busy:
  - Stimulus: start pulses during LOAD and RUN.
  - Required response: ignored; single completion; a start in DONE restarts with cycle_count cleared to 0.
- Watchdog (PE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: pe_halted never asserts.
  - Required response: error=1 after 100 RUN cycles; done=0; pe_execute=0.
